ifetch_queue: RTL and testbench

//   Instruction fetch stage upstream of decode/execute. Owns the fetch PC and issues

---
 rtl/ifetch_queue_pkg.sv | 14 +
 rtl/ifq_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 118 +++++++++++
 tb/tb_ifetch_queue.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared widths, PC step and reset PC for the instruction fetch queue.
package ifetch_queue_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [ILEN-1:0] data;
    logic [XLEN-1:0] pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO with flush and occupancy count; head is shown
// combinationally from the storage registers (no write-to-read bypass).
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full, do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];

  // At full, a push is only taken when the head is leaving in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential fetch with credit-limited requests, in-order
// response buffering, and redirect flush. Optional IFETCH_MISALIGN_EN adds fetch_fault.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, track_pc_q, track_pc_d, target_pc;
  logic [CW-1:0]   outstanding_q, outstanding_d, kill_q, kill_d, fifo_count;
  logic            fire, drop, push, pop, fifo_empty, credit_ok, fault_active;
  ifq_entry_t      push_entry, head_entry;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

  // Requests in flight plus buffered words never exceed DEPTH, so pushes always fit.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(DEPTH);
  assign imem_req  = rst_n && !redirect && !fault_active && credit_ok;
  assign imem_addr = fetch_pc_q;

  assign fire = imem_req && imem_gnt;
  assign drop = imem_rvalid && (kill_q != '0);
  assign push = imem_rvalid && !drop && !redirect;
  assign pop  = inst_valid && inst_ready;

  assign push_entry = '{data: imem_rdata, pc: track_pc_q};

  ifq_fifo #(.DEPTH(DEPTH), .WIDTH($bits(ifq_entry_t))) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head_entry),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign inst_valid  = !fifo_empty && !fault_active;
  assign inst_data   = head_entry.data;
  assign fetch_fault = fault_active;

  always_comb begin
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid);
    fetch_pc_d    = fire ? fetch_pc_q + PC_STEP : fetch_pc_q;
    track_pc_d    = push ? track_pc_q + PC_STEP : track_pc_q;
    kill_d        = drop ? kill_q - CW'(1) : kill_q;
    // Everything still in flight after this cycle belongs to the abandoned path.
    if (redirect) begin
      fetch_pc_d = target_pc;
      track_pc_d = target_pc;
      kill_d     = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      track_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      kill_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      track_pc_q    <= track_pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
    end
  end

`ifdef IFETCH_MISALIGN_EN
  logic            fault_q;
  logic [XLEN-1:0] fault_pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q    <= 1'b0;
      fault_pc_q <= RESET_PC;
    end else if (redirect) begin
      fault_q    <= (redirect_pc[1:0] != 2'b00);
      fault_pc_q <= redirect_pc;
    end
  end

  assign fault_active = fault_q;
  assign inst_pc      = fault_q ? fault_pc_q : head_entry.pc;
`else
  logic unused_lo;
  assign unused_lo    = ^redirect_pc[1:0];
  assign fault_active = 1'b0;
  assign inst_pc      = head_entry.pc;
`endif

`ifndef SYNTHESIS
  a_rvalid_needs_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding_q != '0)
  ) else $error("ifetch_queue: rvalid with no outstanding request");
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised scoreboard bench for ifetch_queue (define IFETCH_MISALIGN_EN to cover the fault path).
module tb_ifetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, inst_data, inst_pc;
  logic        redirect = 1'b0, inst_valid, inst_ready = 1'b0, fetch_fault;

  always #5 clk = ~clk;

  ifetch_queue #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend_q[$];   // granted requests awaiting a response (memory side)
  logic [31:0] exp_q[$];    // PCs of words the consumer should see, in order
  int vectors = 0, miscompares = 0, cyc = 0, epoch = 0, pops = 0;
  int p_gnt = 100, p_ready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
  logic [31:0] model_fetch = RST_PC, model_fault_pc = '0;
  logic        model_fault = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom_range(0, 4095);
    if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | {28'h0, t[3:0]};
`ifdef IFETCH_MISALIGN_EN
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: mid-cycle, all inputs and outputs are stable; account for the coming edge.
  always @(negedge clk) begin : monitor
    req_t        r;
    logic [31:0] p;
    logic        exp_req;
    if (rst_n) begin
      exp_req = !redirect && !model_fault && ((pend_q.size() + exp_q.size()) < DEPTH);
      check("imem_req", imem_req, exp_req);
      check("inst_valid", inst_valid, (exp_q.size() != 0) && !model_fault);
      check("fetch_fault", fetch_fault, model_fault);
      if (model_fault) check("fault_pc", inst_pc, model_fault_pc);
      else             check("imem_addr", imem_addr, model_fetch);
      if (inst_valid && inst_ready && exp_q.size() != 0) begin
        p = exp_q.pop_front();
        pops++;
        $display("pop  cyc=%0d pc=%h data=%h", cyc, inst_pc, inst_data);
        check("inst_pc", inst_pc, p);
        check("inst_data", inst_data, mem_word(p));
      end
      if (redirect) begin
        epoch++;
        exp_q.delete();
`ifdef IFETCH_MISALIGN_EN
        model_fault    = (redirect_pc[1:0] != 2'b00);
        model_fault_pc = redirect_pc;
`endif
      end
      if (imem_rvalid && pend_q.size() != 0) begin
        r = pend_q.pop_front();
        if (r.epoch == epoch) exp_q.push_back(r.addr);
      end
      if (imem_req && imem_gnt) begin
        pend_q.push_back('{model_fetch, epoch, cyc + int'($urandom_range(lat_min, lat_max))});
        model_fetch = model_fetch + 32'd4;
      end
      if (redirect) model_fetch = {redirect_pc[31:2], 2'b00};
    end
  end

  task automatic drive_cycle(input logic force_redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    imem_gnt   = ($urandom_range(0, 99) < p_gnt);
    inst_ready = ($urandom_range(0, 99) < p_ready);
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    if (force_redir) begin
      redirect = 1'b1; redirect_pc = tgt;
    end else if ($urandom_range(0, 99) < p_redir) begin
      redirect = 1'b1; redirect_pc = rand_target();
    end else begin
      redirect = 1'b0; redirect_pc = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_fetch_fault", fetch_fault, 1'b0);
    check("rst_imem_addr", imem_addr, RST_PC);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;

    // Steady stream: always granted, 1-cycle memory, consumer always ready.
    run(40);
    // Stall the consumer so the credit limit fills the FIFO, then drain.
    p_ready = 0;  run(10);
    p_ready = 100; run(20);
    // Three outstanding at latency 3, then redirect.
    lat_min = 3; lat_max = 3; run(10);
    drive_cycle(1'b1, 32'h0000_0100);
    run(20);
    // Redirect while full and popping.
    lat_min = 1; lat_max = 1; p_ready = 0; run(8);
    p_ready = 100; drive_cycle(1'b1, 32'h0000_0040);
    run(10);
    // Wrap of the fetch PC past 2^32.
    drive_cycle(1'b1, 32'hFFFF_FFF8);
    run(10);
    // Randomised traffic, latency, backpressure and redirects.
    p_gnt = 70; p_ready = 70; p_redir = 4; lat_min = 1; lat_max = 4;
    run(400);
    // Reset asserted mid-stream with requests in flight.
    p_redir = 0; p_gnt = 100; lat_min = 3; lat_max = 3; run(6);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    imem_rvalid = 1'b0; redirect = 1'b0; imem_gnt = 1'b0;
    pend_q.delete(); exp_q.delete();
    model_fetch = RST_PC; model_fault = 1'b0; epoch++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_min = 1; lat_max = 2; run(20);
`ifdef IFETCH_MISALIGN_EN
    drive_cycle(1'b1, 32'h0000_0202);
    run(6);
    drive_cycle(1'b1, 32'h0000_0200);
    run(10);
`endif
    p_gnt = 70; p_ready = 70; p_redir = 3; lat_min = 1; lat_max = 4;
    run(100);
    p_redir = 0; run(10);
    check("pop_count_over_100", 32'(pops > 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
